// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Lookup is combinational; updates land on the clock edge.
//
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   flush_i            invalidate every entry on the next edge
//   pc_i               fetch PC to look up
//   lookup_valid_i     pc_i is a real fetch (statistics only)
//   hit_o              pc_i matches a valid entry
//   pred_taken_o       hit and counter MSB set
//   next_pc_o          stored target when predicted taken, else pc_i+4
//   upd_valid_i        resolved-branch update strobe
//   upd_pc_i           PC of the resolved branch
//   upd_taken_i        actual direction
//   upd_target_i       actual taken target
//   upd_mispredict_i   earlier prediction for this branch was wrong
//   lookup_cnt_o       fetch lookup count
//   mispredict_cnt_o   mispredict count
//
// Optional macro BPRED_STATS_EN builds the two 32-bit statistics counters;
// without it both count outputs are tied to zero.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = ADDR_W - $clog2(ENTRIES) - 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              lookup_valid_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] next_pc_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    output logic [31:0]       lookup_cnt_o,
    output logic [31:0]       mispredict_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CTR_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CTR_WNT = CTR_WT - CNT_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [CNT_W-1:0] upd_ctr;

    assign look_idx = pc_i[IDX_W+1:2];
    assign look_tag = pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx  = upd_pc_i[IDX_W+1:2];
    assign upd_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_ctr  = ctr_q[upd_idx];
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Gated by rst_i so the table contents before the first reset edge
    // never leak out as a hit.
    assign hit_o = !rst_i && valid_q[look_idx]
                   && (tag_q[look_idx] == look_tag);
    assign pred_taken_o = hit_o && ctr_q[look_idx][CNT_W-1];
    assign next_pc_o = pred_taken_o ? target_q[look_idx]
                                    : pc_i + ADDR_W'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (flush_i) begin
            // A same-edge update is dropped on purpose.
            valid_q <= '0;
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    target_q[upd_idx] <= upd_target_i;
                    if (upd_ctr != CTR_MAX) begin
                        ctr_q[upd_idx] <= upd_ctr + CNT_W'(1);
                    end
                end else if (upd_ctr != '0) begin
                    ctr_q[upd_idx] <= upd_ctr - CNT_W'(1);
                end
            end else if (upd_taken_i) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target_i;
                ctr_q[upd_idx]    <= CTR_WT;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] lookup_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lookup_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (lookup_valid_i) begin
                lookup_cnt_q <= lookup_cnt_q + 32'd1;
            end
            if (upd_valid_i && upd_mispredict_i) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign lookup_cnt_o     = lookup_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, upd_pc_i[1:0]};
`else
    assign lookup_cnt_o     = '0;
    assign mispredict_cnt_o = '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, upd_pc_i[1:0],
                           lookup_valid_i, upd_mispredict_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=2).
// Expected values are hand-computed from the counter/BTB rules.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc;
    logic        lookup_valid;
    logic        hit;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] lookup_cnt;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

`ifdef BPRED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    branch_predictor #(
        .ADDR_W (32),
        .ENTRIES(16),
        .CNT_W  (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .pc_i            (pc),
        .lookup_valid_i  (lookup_valid),
        .hit_o           (hit),
        .pred_taken_o    (pred_taken),
        .next_pc_o       (next_pc),
        .upd_valid_i     (upd_valid),
        .upd_pc_i        (upd_pc),
        .upd_taken_i     (upd_taken),
        .upd_target_i    (upd_target),
        .upd_mispredict_i(upd_mispredict),
        .lookup_cnt_o    (lookup_cnt),
        .mispredict_cnt_o(mispredict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] a,
                        input logic h, input logic t,
                        input logic [31:0] n);
        pc = a;
        #1;
        check({tag, ".hit"}, {31'd0, hit}, {31'd0, h});
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, ".next"}, next_pc, n);
    endtask

    task automatic upd(input logic [31:0] a, input logic tk,
                       input logic [31:0] tg);
        upd_valid  = 1'b1;
        upd_pc     = a;
        upd_taken  = tk;
        upd_target = tg;
        step();
        upd_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pc = 32'h40; lookup_valid = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;

        #1;
        look("rst_held_pre", 32'h40, 1'b0, 1'b0, 32'h44);
        step();
        step();
        look("rst_held", 32'h40, 1'b0, 1'b0, 32'h44);
        rst = 1'b0;
        look("post_rst", 32'h40, 1'b0, 1'b0, 32'h44);
        check("cnt_rst.look", lookup_cnt, 32'd0);
        check("cnt_rst.misp", mispredict_cnt, 32'd0);

        // Allocation: the same-cycle lookup still sees the old table.
        upd_valid = 1'b1; upd_pc = 32'h40;
        upd_taken = 1'b1; upd_target = 32'h100;
        look("alloc_same_cyc", 32'h40, 1'b0, 1'b0, 32'h44);
        step();
        upd_valid = 1'b0;
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        upd(32'h40, 1'b0, 32'h0);
        look("nt1_ctr1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0);
        look("nt2_ctr0", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0);
        look("nt3_floor", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100);
        look("t1_ctr1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h104);
        look("t2_ctr2", 32'h40, 1'b1, 1'b1, 32'h104);

        // Alias at index 0 with a different tag.
        upd(32'h80, 1'b1, 32'h200);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);
        upd(32'hC0, 1'b0, 32'h300);
        look("nt_miss_c0", 32'hC0, 1'b0, 1'b0, 32'hC4);
        look("nt_miss_80", 32'h80, 1'b1, 1'b1, 32'h200);

        // Saturation at the top: 2 -> 3 -> 3 -> 2 -> 1.
        upd(32'h80, 1'b1, 32'h200);
        upd(32'h80, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 32'h0);
        look("sat_ctr2", 32'h80, 1'b1, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 32'h0);
        look("sat_ctr1", 32'h80, 1'b1, 1'b0, 32'h84);

        // Flush wins over a simultaneous allocation.
        flush = 1'b1;
        upd(32'h44, 1'b1, 32'h300);
        flush = 1'b0;
        look("flush_80", 32'h80, 1'b0, 1'b0, 32'h84);
        look("flush_44", 32'h44, 1'b0, 1'b0, 32'h48);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Statistics: 5 valid lookups, 2 counted mispredicts.
        lookup_valid = 1'b1;
        upd_mispredict = 1'b1;
        upd(32'hC0, 1'b0, 32'h0);
        step();
        upd(32'hC0, 1'b0, 32'h0);
        step();
        step();
        lookup_valid = 1'b0;
        step();
        upd_mispredict = 1'b0;
        check("stats.look", lookup_cnt, STATS ? 32'd5 : 32'd0);
        check("stats.misp", mispredict_cnt, STATS ? 32'd2 : 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stats_flush.look", lookup_cnt, STATS ? 32'd5 : 32'd0);
        check("stats_flush.misp", mispredict_cnt, STATS ? 32'd2 : 32'd0);

        // Reset mid-training loses the entry and the counts.
        upd(32'h80, 1'b1, 32'h200);
        look("pre_rst2", 32'h80, 1'b1, 1'b1, 32'h200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        look("post_rst2", 32'h80, 1'b0, 1'b0, 32'h84);
        check("rst2.look", lookup_cnt, 32'd0);
        check("rst2.misp", mispredict_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised IF-stage branch predictor: direct-mapped branch target buffer with per-entry saturating direction counters.
- Replaces the fixed pc+4 next-PC path: IF looks up the current PC and gets a next-PC guess in the same cycle.
- ID/EX resolves the branch and writes the outcome back through the update port.
- A wrong guess still triggers the existing IF/ID flush; this block only trains on it.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, number of BTB entries; power of two, minimum 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width in bits; minimum 1.
- TAG_W, ADDR_W-IDX_W-2, stored tag width; must equal ADDR_W-IDX_W-2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  invalidate all entries on the next edge.
- pc_i  in  ADDR_W  IF-stage PC to look up.
- lookup_valid_i  in  1  pc_i is a real fetch; affects statistics only.
- hit_o  out  1  pc_i matches a valid entry (combinational).
- pred_taken_o  out  1  hit_o and counter MSB = 1 (combinational).
- next_pc_o  out  ADDR_W  stored target if pred_taken_o, else pc_i+4 (combinational).
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  ADDR_W  PC of the resolved branch.
- upd_taken_i  in  1  actual branch direction.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_mispredict_i  in  1  the earlier prediction for this branch was wrong.
- lookup_cnt_o  out  32  lookup count (optional feature).
- mispredict_cnt_o  out  32  mispredict count (optional feature).

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr.
- Lookup is purely combinational from table state; zero-cycle latency.
- Update takes effect at the rising edge when upd_valid_i = 1.
  - Update hit:
    - upd_taken_i = 1: ctr saturating +1, capped at 2^CNT_W-1; target <= upd_target_i.
    - upd_taken_i = 0: ctr saturating -1, floored at 0; target unchanged.
  - Update miss (invalid entry or tag mismatch):
    - upd_taken_i = 1: allocate, overwriting any occupant. valid=1, tag, target, ctr = 2^(CNT_W-1) (weakly taken).
    - upd_taken_i = 0: no allocation; table unchanged.
- Lookup and update in the same cycle, same index: lookup returns pre-update contents; no bypass.
- Priority per edge is rst_i > flush_i > upd_valid_i.
  - flush_i clears every valid bit.
  - A simultaneous update is dropped, not applied after the flush.
- rst_i: valid bits cleared, ctr = 2^(CNT_W-1)-1 (weakly not-taken), targets/tags don't-care.
- Output values while rst_i is held and after reset: hit_o = 0, pred_taken_o = 0, next_pc_o = pc_i+4.
- Reset asserted mid-training loses all history; the first post-reset lookups miss.
- pc_i+4 wraps modulo 2^ADDR_W; no overflow flag.
- CNT_W = 1: ctr is a last-outcome bit; on allocate, ctr = 1.
- Branch instructions never stall the predictor; updates arrive at most one per cycle.

Optional Feature:
- Macro BPRED_STATS_EN.
- Defined:
  - lookup_cnt_o increments each edge with lookup_valid_i = 1.
  - mispredict_cnt_o increments each edge with upd_valid_i = 1 and upd_mispredict_i = 1.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0 on rst_i.
  - flush_i does not clear them.
- Undefined: counters not built; lookup_cnt_o and mispredict_cnt_o tied to 0; port list unchanged.

Test Plan (ENTRIES=16, CNT_W=2, ADDR_W=32):
- Reset, then pc_i=0x0000_0040 -> hit_o=0, pred_taken_o=0, next_pc_o=0x0000_0044.
- Update pc=0x40, taken, target=0x100; next cycle pc_i=0x40 -> hit_o=1, pred_taken_o=1, next_pc_o=0x100.
- Two not-taken updates at pc=0x40 after the allocate (ctr 2->1->0) -> pred_taken_o=0, next_pc_o=0x44, hit_o=1.
  - Then one taken update -> still not-taken (ctr=1); a second taken update -> taken.
- Alias test:
  - Allocate pc=0x40 (index 0), then taken update pc=0x80 target 0x200 (index 0, different tag).
  - Lookup 0x40 -> hit_o=0; lookup 0x80 -> next_pc_o=0x200.
  - Not-taken update on a miss at pc=0xC0 -> table unchanged.
- Same-cycle edge cases:
  - Allocating update and lookup of the same PC in one cycle -> that cycle misses; next cycle hits.
  - flush_i together with an allocating update -> all lookups miss afterward.
  - pc_i=0xFFFF_FFFC on a miss -> next_pc_o=0x0000_0000.
- BPRED_STATS_EN defined:
  - 5 valid lookups plus 2 updates with upd_mispredict_i=1 -> lookup_cnt_o=5, mispredict_cnt_o=2.
  - flush_i -> counts unchanged; rst_i -> both counts 0.
  - Undefined build -> both outputs read 0 throughout.
